conv_result_drain: RTL and testbench



---
 rtl/conv_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/conv_result_drain.sv | 118 +++++++++++
 tb/tb_conv_result_drain.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and activation helpers for the systolic conv datapath.
package conv_pkg;

  localparam int unsigned LANE_W        = 16;
  localparam int unsigned LANES         = 4;
  localparam int unsigned ROWS_PER_TILE = 4;

  typedef logic signed [LANE_W-1:0]       lane_t;
  typedef logic        [LANE_W*LANES-1:0] row_t;

  // Leaky-ReLU, slope 1/8; arithmetic shift rounds toward -inf.
  function automatic lane_t leaky(input lane_t x);
    return x[LANE_W-1] ? (x >>> 3) : x;
  endfunction

  function automatic row_t leaky_row(input row_t r);
    row_t y;
    y = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      y[i*LANE_W +: LANE_W] = leaky(lane_t'(r[i*LANE_W +: LANE_W]));
    end
    return y;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/conv_result_drain.sv
// Result-port drain: whole-tile admission, optional leaky-ReLU, valid/ready output.
// Leaky-ReLU is built in when CONV_DRAIN_LEAKY_EN is defined.
module conv_result_drain
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      i_Data,
  input  logic             i_Data_en,
  input  logic             i_clr_ovf,
  output logic [63:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_tile_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 2;

  logic [1:0]       rowidx_q, rowidx_d;
  logic             keep_q, keep_d;
  logic             stage_valid_q, stage_valid_d;
  row_t             stage_data_q, stage_data_d;
  logic             stage_last_q, stage_last_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] tile_cnt_q, tile_cnt_d;

  logic [AW:0]      fifo_count;
  logic             fifo_full, fifo_empty;
  logic [64:0]      fifo_rdata;
  logic [OW-1:0]    occ;
  logic             admit, keep_now, drop, pop;
  row_t             act_data;

`ifdef CONV_DRAIN_LEAKY_EN
  assign act_data = leaky_row(i_Data);
`else
  assign act_data = i_Data;
`endif

  always_comb begin
    rowidx_d      = rowidx_q;
    keep_d        = keep_q;
    stage_data_d  = stage_data_q;
    stage_last_d  = stage_last_q;
    tile_cnt_d    = tile_cnt_q;

    // The stage word still counts: it lands in the FIFO next cycle.
    occ      = {1'b0, fifo_count} + OW'(stage_valid_q);
    admit    = !fifo_full && ((occ + OW'(ROWS_PER_TILE)) <= OW'(DEPTH));
    keep_now = (rowidx_q == 2'd0) ? admit : keep_q;
    drop     = i_Data_en && (rowidx_q == 2'd0) && !admit;

    if (i_Data_en) begin
      rowidx_d = rowidx_q + 2'd1;
      if (rowidx_q == 2'd0) keep_d = admit;
    end

    stage_valid_d = i_Data_en && keep_now;
    if (i_Data_en && keep_now) begin
      stage_data_d = act_data;
      stage_last_d = (rowidx_q == 2'd3);
    end

    ovf_d = drop | (ovf_q & ~i_clr_ovf);

    pop = !fifo_empty && m_tready;
    if (pop && fifo_rdata[64]) tile_cnt_d = tile_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rowidx_q      <= '0;
      keep_q        <= 1'b0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      stage_last_q  <= 1'b0;
      ovf_q         <= 1'b0;
      tile_cnt_q    <= '0;
    end else begin
      rowidx_q      <= rowidx_d;
      keep_q        <= keep_d;
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      stage_last_q  <= stage_last_d;
      ovf_q         <= ovf_d;
      tile_cnt_q    <= tile_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (65),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stage_valid_q),
    .wdata ({stage_last_q, stage_data_q}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head is masked when empty so the idle bus reads zero, never stale RAM.
  assign m_tvalid   = !fifo_empty;
  assign m_tdata    = fifo_empty ? '0 : fifo_rdata[63:0];
  assign m_tlast    = !fifo_empty && fifo_rdata[64];
  assign o_overflow = ovf_q;
  assign o_tile_cnt = tile_cnt_q;

endmodule

// File: tb/tb_conv_result_drain.sv
// Directed bench for conv_result_drain; expected leaky values follow CONV_DRAIN_LEAKY_EN.
module tb_conv_result_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] i_Data = '0;
  logic        i_Data_en = 1'b0;
  logic        i_clr_ovf = 1'b0;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        o_overflow;
  logic [15:0] o_tile_cnt;

  int tests = 0;
  int fails = 0;

  logic [64:0] got [$];
  int          stall_seen = 0;
  int          stall_err  = 0;
  logic        prev_stall = 1'b0;
  logic [65:0] prev_snap  = '0;

  logic [63:0] TA [4] = '{64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008,
                          64'h0009_000A_000B_000C, 64'h000D_000E_000F_0010};
  logic [63:0] TB [4] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_0888,
                          64'h0999_0AAA_0BBB_0CCC, 64'h0DDD_0EEE_0FFF_1000};
  logic [63:0] TC [4] = '{64'h2000_2001_2002_2003, 64'h2004_2005_2006_2007,
                          64'h2008_2009_200A_200B, 64'h200C_200D_200E_200F};

  conv_result_drain #(.DEPTH(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_Data     (i_Data),
    .i_Data_en  (i_Data_en),
    .i_clr_ovf  (i_clr_ovf),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .o_overflow (o_overflow),
    .o_tile_cnt (o_tile_cnt)
  );

  always #5 clk = ~clk;

  // Records accepted words and whether stalled outputs stayed put.
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      stall_seen++;
      if ({m_tvalid, m_tlast, m_tdata} !== prev_snap) stall_err++;
    end
    if (rst_n && m_tvalid && m_tready) got.push_back({m_tlast, m_tdata});
    prev_stall = rst_n && m_tvalid && !m_tready;
    prev_snap  = {m_tvalid, m_tlast, m_tdata};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_tile(input logic [63:0] w [4]);
    for (int i = 0; i < 4; i++) begin
      i_Data_en = 1'b1;
      i_Data    = w[i];
      tick();
    end
    i_Data_en = 1'b0;
    i_Data    = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid got=%b exp=0", m_tvalid); end
    tests++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast got=%b exp=0", m_tlast); end
    tests++; if (m_tdata !== 64'h0) begin fails++; $display("FAIL rst_tdata got=%h exp=0", m_tdata); end
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL rst_ovf got=%b exp=0", o_overflow); end
    tests++; if (o_tile_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt got=%0d exp=0", o_tile_cnt); end
    rst_n = 1'b1;
    idle(2);
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL post_rst_tvalid got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_single();
    got.delete();
    m_tready  = 1'b1;
    i_Data_en = 1'b1;
    i_Data    = TA[0];
    tick();
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL lat_early got=%b exp=0", m_tvalid); end
    i_Data = TA[1];
    tick();
    tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL lat_valid got=%b exp=1", m_tvalid); end
    tests++; if (m_tdata !== TA[0]) begin fails++; $display("FAIL lat_data got=%h exp=%h", m_tdata, TA[0]); end
    tests++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL lat_last got=%b exp=0", m_tlast); end
    i_Data = TA[2];
    tick();
    i_Data = TA[3];
    tick();
    i_Data_en = 1'b0;
    i_Data    = '0;
    idle(6);
    tests++; if (got.size() != 4) begin fails++; $display("FAIL single_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got[i] !== {(i == 3), TA[i]}) begin
        fails++; $display("FAIL single_word%0d got=%h exp=%h", i, got[i], {(i == 3), TA[i]});
      end
    end
    tests++; if (o_tile_cnt !== 16'd1) begin fails++; $display("FAIL single_cnt got=%0d exp=1", o_tile_cnt); end
  endtask

  task automatic test_leaky();
    logic [63:0] w [4];
    logic [63:0] e0, e1;
    w = '{64'hFFF0_0010_8000_7FFF, 64'h0000_FFFF_0001_FFF8, TA[2], TA[3]};
`ifdef CONV_DRAIN_LEAKY_EN
    e0 = 64'hFFFE_0010_F000_7FFF;
    e1 = 64'h0000_FFFF_0001_FFFF;
`else
    e0 = 64'hFFF0_0010_8000_7FFF;
    e1 = 64'h0000_FFFF_0001_FFF8;
`endif
    got.delete();
    m_tready = 1'b1;
    send_tile(w);
    idle(6);
    tests++; if (got.size() != 4) begin fails++; $display("FAIL leaky_count got=%0d exp=4", got.size()); end
    tests++; if (got[0] !== {1'b0, e0}) begin fails++; $display("FAIL leaky_w0 got=%h exp=%h", got[0], {1'b0, e0}); end
    tests++; if (got[1] !== {1'b0, e1}) begin fails++; $display("FAIL leaky_w1 got=%h exp=%h", got[1], {1'b0, e1}); end
    tests++; if (got[3] !== {1'b1, TA[3]}) begin fails++; $display("FAIL leaky_w3 got=%h exp=%h", got[3], {1'b1, TA[3]}); end
    tests++; if (o_tile_cnt !== 16'd2) begin fails++; $display("FAIL leaky_cnt got=%0d exp=2", o_tile_cnt); end
  endtask

  task automatic test_overflow();
    got.delete();
    m_tready = 1'b0;
    send_tile(TA);
    idle(8);
    send_tile(TB);
    idle(8);
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got=%b exp=0", o_overflow); end
    send_tile(TC);
    idle(8);
    tests++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got=%b exp=1", o_overflow); end
    tests++; if (got.size() != 0) begin fails++; $display("FAIL ovf_stalled got=%0d exp=0", got.size()); end
    tests++; if (m_tdata !== TA[0]) begin fails++; $display("FAIL ovf_head got=%h exp=%h", m_tdata, TA[0]); end
    m_tready = 1'b1;
    idle(12);
    tests++; if (got.size() != 8) begin fails++; $display("FAIL ovf_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got[i] !== {(i == 3), TA[i]}) begin
        fails++; $display("FAIL ovf_a%0d got=%h exp=%h", i, got[i], {(i == 3), TA[i]});
      end
      tests++;
      if (got[i+4] !== {(i == 3), TB[i]}) begin
        fails++; $display("FAIL ovf_b%0d got=%h exp=%h", i, got[i+4], {(i == 3), TB[i]});
      end
    end
    tests++; if (o_tile_cnt !== 16'd4) begin fails++; $display("FAIL ovf_cnt got=%0d exp=4", o_tile_cnt); end
  endtask

  task automatic test_toggle();
    got.delete();
    stall_seen = 0;
    stall_err  = 0;
    m_tready   = 1'b0;
    send_tile(TA);
    idle(8);
    send_tile(TC);
    idle(4);
    for (int i = 0; i < 24; i++) begin
      m_tready = ~m_tready;
      tick();
    end
    m_tready = 1'b1;
    idle(3);
    tests++; if (stall_err != 0) begin fails++; $display("FAIL tog_stable got=%0d exp=0", stall_err); end
    tests++; if (stall_seen == 0) begin fails++; $display("FAIL tog_stalls got=%0d exp=>0", stall_seen); end
    tests++; if (got.size() != 8) begin fails++; $display("FAIL tog_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got[i] !== {(i == 3), TA[i]}) begin
        fails++; $display("FAIL tog_a%0d got=%h exp=%h", i, got[i], {(i == 3), TA[i]});
      end
      tests++;
      if (got[i+4] !== {(i == 3), TC[i]}) begin
        fails++; $display("FAIL tog_c%0d got=%h exp=%h", i, got[i+4], {(i == 3), TC[i]});
      end
    end
    tests++; if (o_tile_cnt !== 16'd6) begin fails++; $display("FAIL tog_cnt got=%0d exp=6", o_tile_cnt); end
  endtask

  task automatic test_clr_drop();
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL clr_plain got=%b exp=0", o_overflow); end
    got.delete();
    m_tready = 1'b0;
    send_tile(TB);
    idle(8);
    send_tile(TA);
    idle(8);
    i_Data_en = 1'b1;
    i_Data    = TC[0];
    i_clr_ovf = 1'b1;
    tick();
    tests++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL clr_set_wins got=%b exp=1", o_overflow); end
    i_Data = TC[1];
    tick();
    i_clr_ovf = 1'b0;
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL clr_next got=%b exp=0", o_overflow); end
    i_Data = TC[2];
    tick();
    i_Data = TC[3];
    tick();
    i_Data_en = 1'b0;
    i_Data    = '0;
    m_tready  = 1'b1;
    idle(12);
    tests++; if (got.size() != 8) begin fails++; $display("FAIL clr_count got=%0d exp=8", got.size()); end
    tests++; if (got[0] !== {1'b0, TB[0]}) begin fails++; $display("FAIL clr_first got=%h exp=%h", got[0], {1'b0, TB[0]}); end
    tests++; if (got[7] !== {1'b1, TA[3]}) begin fails++; $display("FAIL clr_last got=%h exp=%h", got[7], {1'b1, TA[3]}); end
    tests++; if (o_tile_cnt !== 16'd8) begin fails++; $display("FAIL clr_cnt got=%0d exp=8", o_tile_cnt); end
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0;
    send_tile(TB);
    idle(8);
    tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL rmid_pre got=%b exp=1", m_tvalid); end
    i_Data_en = 1'b1;
    i_Data    = TC[0];
    tick();
    i_Data = TC[1];
    tick();
    rst_n     = 1'b0;
    i_Data_en = 1'b0;
    i_Data    = '0;
    #1;
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rmid_tvalid got=%b exp=0", m_tvalid); end
    tests++; if (m_tdata !== 64'h0) begin fails++; $display("FAIL rmid_tdata got=%h exp=0", m_tdata); end
    tests++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL rmid_tlast got=%b exp=0", m_tlast); end
    tests++; if (o_tile_cnt !== 16'd0) begin fails++; $display("FAIL rmid_cnt got=%0d exp=0", o_tile_cnt); end
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL rmid_ovf got=%b exp=0", o_overflow); end
    tick();
    tick();
    rst_n    = 1'b1;
    m_tready = 1'b1;
    got.delete();
    tick();
    send_tile(TA);
    idle(6);
    tests++; if (got.size() != 4) begin fails++; $display("FAIL rmid_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got[i] !== {(i == 3), TA[i]}) begin
        fails++; $display("FAIL rmid_word%0d got=%h exp=%h", i, got[i], {(i == 3), TA[i]});
      end
    end
    tests++; if (o_tile_cnt !== 16'd1) begin fails++; $display("FAIL rmid_cnt_after got=%0d exp=1", o_tile_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_leaky();
    test_overflow();
    test_toggle();
    test_clr_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
